mem_arbiter: RTL and testbench

Three-way arbiter that shares the miner's single-port data memory between the host memory controller, the accelerator block and the CPU data port. It issues at most one memory access per cycle and returns read data one cycle later, tagged to the requester that issued it. A requester can lock ownership for back-to-back bursts, such as a 512-bit host cache line of 16 words. Ownership returns to the other requesters when the lock is released or a hold limit expires.

---
 rtl/miner_pkg.sv | 41 ++++
 rtl/mem_arbiter_rr_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/miner_pkg.sv
// -----------------------------------------------------------------------------
// miner_pkg
// Shared definitions for the miner's data-memory arbiter.
//   NUM_REQ          number of requesters sharing the memory port
//   REQ_HOST/ACC/CPU requester indices (host memory controller, accelerator, CPU)
//   arb_state_t      arbiter ownership state
//   rr_wrap()        modulo-NUM_REQ step used by the round-robin search
//   to_onehot()      requester index to one-hot vector
// -----------------------------------------------------------------------------
package miner_pkg;

    localparam int NUM_REQ = 3;

    typedef logic [1:0] req_idx_t;

    localparam req_idx_t REQ_HOST = 2'd0;
    localparam req_idx_t REQ_ACC  = 2'd1;
    localparam req_idx_t REQ_CPU  = 2'd2;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // (base + step) mod NUM_REQ
    function automatic req_idx_t rr_wrap(input req_idx_t base, input int unsigned step);
        int unsigned s;
        s = (int'(unsigned'(base)) + step) % NUM_REQ;
        return req_idx_t'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] to_onehot(input req_idx_t idx);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (idx == req_idx_t'(i)) oh[i] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational 3-input round-robin selector. Searches last+1, last+2, last
// (mod 3) and picks the first requester with req set.
//   req   in  requester request vector
//   last  in  index of the most recently served requester
//   gnt   out one-hot pick (all zero when req is zero)
//   idx   out index of the pick (equals last when nothing is picked)
// With req[0] forced low the same search degenerates to a 2-way rotation
// between requesters 1 and 2.
// -----------------------------------------------------------------------------
module rr_pick
    import miner_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           last,
    output logic [NUM_REQ-1:0] gnt,
    output req_idx_t           idx
);

    logic     found;
    req_idx_t cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    always_comb begin
        gnt   = '0;
        idx   = last;
        found = 1'b0;
        cand  = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = rr_wrap(last, k);
            if (!found && req[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares the single-port data memory between the host memory controller (0),
// the accelerator (1) and the CPU (2). One access per cycle, read data one
// cycle later tagged by rvalid. A requester may lock ownership for bursts;
// ownership is released when lock drops, the owner stops requesting, or
// MAX_LOCK beats have been accepted.
//
// Parameters: DATA_WIDTH, ADDR_WIDTH, MAX_LOCK
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req/we/lock [3]   per-requester request, write enable, keep-ownership
//   addr, wdata       packed per-requester address / write data
//   gnt [3]           one-hot grant (combinational)
//   rvalid [3]        one-hot read-data valid (registered)
//   rdata             shared read data, qualified by rvalid, holds otherwise
//   busy              a lock owner exists
//   mem_*             memory port; mem_rdata valid the cycle after a read
//
// Build option: define MEM_ARB_HOST_PRIO_EN to give the host strict priority
// in IDLE; requesters 1 and 2 then rotate only while the host is quiet.
// -----------------------------------------------------------------------------
module mem_arbiter
    import miner_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_LOCK   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          busy,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOCK);

    // ------------------------------------------------------------------ state
    arb_state_t             state_q,    state_d;
    req_idx_t               owner_q,    owner_d;
    req_idx_t               rr_last_q,  rr_last_d;
    logic [CNT_W-1:0]       lock_cnt_q, lock_cnt_d;
    logic [NUM_REQ-1:0]     rvalid_q,   rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q,    rdata_d;

    // ------------------------------------------------------------ arbitration
    logic [NUM_REQ-1:0] arb_gnt;
    req_idx_t           arb_idx;

`ifdef MEM_ARB_HOST_PRIO_EN
    // Host wins outright; the rotator only sees the accelerator and the CPU.
    logic [NUM_REQ-1:0] rr_gnt;
    req_idx_t           rr_idx;

    rr_pick u_rr_pick (
        .req  (req & 3'b110),
        .last (rr_last_q),
        .gnt  (rr_gnt),
        .idx  (rr_idx)
    );

    always_comb begin
        if (req[REQ_HOST]) begin
            arb_gnt = to_onehot(REQ_HOST);
            arb_idx = REQ_HOST;
        end else begin
            arb_gnt = rr_gnt;
            arb_idx = rr_idx;
        end
    end
`else
    rr_pick u_rr_pick (
        .req  (req),
        .last (rr_last_q),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );
`endif

    // ------------------------------------------------- grant and memory mux
    req_idx_t              acc_idx;
    logic                  accept;
    logic                  we_sel;
    logic                  lock_sel;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] wdata_sel;

    always_comb begin
        gnt     = '0;
        acc_idx = arb_idx;
        if (!rst) begin
            if (state_q == IDLE) begin
                gnt = arb_gnt;
            end else begin
                // Only the owner may be served while a lock is held.
                acc_idx = owner_q;
                gnt     = to_onehot(owner_q) & {NUM_REQ{req[owner_q]}};
            end
        end
    end

    assign accept = |(req & gnt);

    always_comb begin
        we_sel    = 1'b0;
        lock_sel  = 1'b0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_idx == req_idx_t'(i)) begin
                we_sel    = we[i];
                lock_sel  = lock[i];
                addr_sel  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wdata_sel = wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign mem_en    = accept;
    assign mem_we    = accept & we_sel;
    assign mem_addr  = addr_sel;
    assign mem_wdata = wdata_sel;

    // ---------------------------------------------------------- next state
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        rr_last_d  = rr_last_q;
        rvalid_d   = '0;
        // Capture the returning word so rdata keeps it after rvalid drops.
        rdata_d    = (|rvalid_q) ? mem_rdata : rdata_q;

        if (accept) begin
            rr_last_d = acc_idx;
            if (!we_sel) rvalid_d = to_onehot(acc_idx);
        end

        case (state_q)
            IDLE: begin
                // With MAX_LOCK of 1 the first beat already hits the limit,
                // so a lock never takes effect.
                if (accept && lock_sel && (MAX_LOCK > 1)) begin
                    state_d    = OWNED;
                    owner_d    = acc_idx;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            OWNED: begin
                if (!req[owner_q]) begin
                    state_d = IDLE;
                end else if (accept) begin
                    lock_cnt_d = cnt_inc;
                    // Forced release at the hold limit regardless of lock.
                    if (!lock_sel || (cnt_inc == CNT_MAX)) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------------------- flops
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= REQ_HOST;
            rr_last_q  <= REQ_CPU;    // host gets first priority after reset
            lock_cnt_q <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_last_q  <= rr_last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
        end
    end

    // ------------------------------------------------------------- outputs
    assign rvalid = rvalid_q;
    assign rdata  = (|rvalid_q) ? mem_rdata : rdata_q;
    assign busy   = (state_q == OWNED);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: a per-cycle vector table covering
// reset release, round-robin rotation, a locked host burst, lock timeout,
// owner drop and host/CPU contention, followed by a hand-written reset-mid-
// lock sequence. Read data is checked through a scoreboard queue filled when
// a read grant is expected and drained when rvalid is due.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int DW = 32;
    localparam int AW = 16;

`ifdef MEM_ARB_HOST_PRIO_EN
    localparam bit HP = 1'b1;
`else
    localparam bit HP = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [2:0]     req, we, lock;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic [2:0]     gnt, rvalid;
    logic [DW-1:0]  rdata;
    logic           busy;
    logic           mem_en, mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------ memory model
    logic [DW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = pattern(AW'(i));
        mem_rdata = '0;
    end

    always @(posedge clk) begin
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
        if (mem_en && mem_we)  mem[mem_addr] <= mem_wdata;
    end

    // ------------------------------------------------------- bookkeeping
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [DW-1:0] last_rd = '0;

    typedef struct {
        int         due;
        logic [2:0] who;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sb[$];

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [2:0]  lock;
        logic [15:0] a0;
        logic [2:0]  exp_gnt;
        logic        exp_busy;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] exp_addr(input int i, input logic [15:0] a0v);
        return (i == 0) ? a0v : (i == 1) ? 16'h0020 : 16'h0030;
    endfunction

    function automatic logic [DW-1:0] exp_wdata(input int i, input logic [15:0] a0v);
        return (i == 0) ? {16'hBEEF, a0v} : (i == 1) ? 32'hACC0_0020 : 32'hC0C0_0030;
    endfunction

    // One clock cycle: drive after the edge, check at the falling edge.
    task automatic do_cycle(input logic rst_v, input logic [2:0] r, input logic [2:0] w,
                            input logic [2:0] l, input logic [15:0] a0v,
                            input logic [2:0] eg, input logic eb);
        rd_t e;
        int  gi;
        rst   = rst_v;
        req   = r;
        we    = w;
        lock  = l;
        addr  = {exp_addr(2, a0v), exp_addr(1, a0v), exp_addr(0, a0v)};
        wdata = {exp_wdata(2, a0v), exp_wdata(1, a0v), exp_wdata(0, a0v)};
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rvalid", 32'(rvalid), 32'(e.who));
            check("rdata", rdata, e.data);
            last_rd = e.data;
        end else begin
            check("rvalid_idle", 32'(rvalid), 32'd0);
            check("rdata_hold", rdata, last_rd);
        end
        check("busy", 32'(busy), 32'(eb));
        check("gnt", 32'(gnt), 32'(eg));
        check("mem_en", 32'(mem_en), 32'(|eg));
        gi = -1;
        for (int i = 0; i < 3; i++) if (eg[i]) gi = i;
        if (gi >= 0) begin
            check("mem_addr", 32'(mem_addr), 32'(exp_addr(gi, a0v)));
            check("mem_we", 32'(mem_we), 32'(w[gi]));
            if (w[gi]) check("mem_wdata", mem_wdata, exp_wdata(gi, a0v));
            else sb.push_back('{due: cyc + 1, who: eg, data: pattern(exp_addr(gi, a0v))});
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst_v) begin
            sb.delete();
            last_rd = '0;
        end
    endtask

    task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                       input logic [15:0] a0v, input logic [2:0] eg_rr,
                       input logic [2:0] eg_hp, input logic eb);
        vecs.push_back('{req: r, we: w, lock: l, a0: a0v,
                         exp_gnt: (HP ? eg_hp : eg_rr), exp_busy: eb});
    endtask

    initial begin
        rst = 1'b1; req = 3'b111; we = '0; lock = '0; addr = '0; wdata = '0;

        // Round-robin from reset: host first, then rotate; idle keeps pointer.
        add(3'b111, 3'b000, 3'b000, 16'h0010, 3'b001, 3'b001, 1'b0);
        add(3'b111, 3'b000, 3'b000, 16'h0010, 3'b010, 3'b001, 1'b0);
        add(3'b111, 3'b000, 3'b000, 16'h0010, 3'b100, 3'b001, 1'b0);
        add(3'b111, 3'b000, 3'b000, 16'h0010, 3'b001, 3'b001, 1'b0);
        add(3'b000, 3'b000, 3'b000, 16'h0010, 3'b000, 3'b000, 1'b0);
        add(3'b111, 3'b000, 3'b000, 16'h0010, 3'b010, 3'b001, 1'b0);
        add(3'b100, 3'b000, 3'b000, 16'h0010, 3'b100, 3'b100, 1'b0);
        // Host write burst of 16 beats with the CPU waiting.
        for (int k = 0; k < 16; k++)
            add(3'b101, 3'b001, (k == 15) ? 3'b000 : 3'b001, 16'(16'h0100 + k),
                3'b001, 3'b001, (k != 0));
        add(3'b100, 3'b000, 3'b000, 16'h0010, 3'b100, 3'b100, 1'b0);
        // Accelerator holds lock for 20 beats; forced release after 16.
        for (int k = 0; k < 16; k++)
            add(3'b110, 3'b000, 3'b010, 16'h0010, 3'b010, 3'b010, (k != 0));
        add(3'b110, 3'b000, 3'b010, 16'h0010, 3'b100, 3'b100, 1'b0);
        add(3'b110, 3'b000, 3'b010, 16'h0010, 3'b010, 3'b010, 1'b0);
        add(3'b110, 3'b000, 3'b010, 16'h0010, 3'b010, 3'b010, 1'b1);
        add(3'b110, 3'b000, 3'b000, 16'h0010, 3'b010, 3'b010, 1'b1);
        // CPU locks, host blocked, CPU drops request, host served next.
        add(3'b100, 3'b000, 3'b100, 16'h0010, 3'b100, 3'b100, 1'b0);
        add(3'b101, 3'b000, 3'b100, 16'h0010, 3'b100, 3'b100, 1'b1);
        add(3'b001, 3'b000, 3'b000, 16'h0010, 3'b000, 3'b000, 1'b1);
        add(3'b001, 3'b000, 3'b000, 16'h0010, 3'b001, 3'b001, 1'b0);
        // Continuous host plus CPU contention.
        add(3'b101, 3'b000, 3'b000, 16'h0010, 3'b100, 3'b001, 1'b0);
        add(3'b101, 3'b000, 3'b000, 16'h0010, 3'b001, 3'b001, 1'b0);
        add(3'b101, 3'b000, 3'b000, 16'h0010, 3'b100, 3'b001, 1'b0);
        add(3'b100, 3'b000, 3'b000, 16'h0010, 3'b100, 3'b100, 1'b0);

        // Reset held two cycles with all requests up.
        @(posedge clk);
        #1;
        do_cycle(1'b1, 3'b111, 3'b000, 3'b000, 16'h0010, 3'b000, 1'b0);
        do_cycle(1'b1, 3'b111, 3'b000, 3'b000, 16'h0010, 3'b000, 1'b0);

        foreach (vecs[i])
            do_cycle(1'b0, vecs[i].req, vecs[i].we, vecs[i].lock, vecs[i].a0,
                     vecs[i].exp_gnt, vecs[i].exp_busy);

        // Reset while a lock is held and a read is returning.
        do_cycle(1'b0, 3'b001, 3'b000, 3'b001, 16'h0040, 3'b001, 1'b0);
        do_cycle(1'b1, 3'b001, 3'b000, 3'b001, 16'h0041, 3'b000, 1'b1);
        do_cycle(1'b0, 3'b000, 3'b000, 3'b000, 16'h0010, 3'b000, 1'b0);
        do_cycle(1'b0, 3'b110, 3'b000, 3'b000, 16'h0010, 3'b010, 1'b0);
        do_cycle(1'b0, 3'b000, 3'b000, 3'b000, 16'h0010, 3'b000, 1'b0);

        // Burst data landed in memory.
        for (int k = 0; k < 16; k++)
            check("burst_mem", mem[16'h0100 + k], {16'hBEEF, 16'(16'h0100 + k)});
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
